// File: rtl/exp_series_engine.sv
// Truncated Taylor series e^x = sum x^n/n! in unsigned Q(WIDTH-FRAC).FRAC with one shared multiplier.
// Latency 3*(nt-1)+2 cycles from accept; DONE holds while out_ready_i=0, inputs ignored unless idle.
module exp_series_engine #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 14,
    parameter int TERMS = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic [WIDTH-1:0]           x_i,
    input  logic [$clog2(TERMS+1)-1:0] n_terms_i,
    output logic                       in_ready_o,
    output logic                       busy_o,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [WIDTH-1:0]           result_o
);

    localparam int KW = $clog2(TERMS+1);
    localparam logic [WIDTH-1:0] ONE_FX = WIDTH'(1) << FRAC;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MUL_X,
        S_MUL_R,
        S_ACC,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] xr_q, xr_d;
    logic [WIDTH-1:0] t_q, t_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [KW-1:0]    k_q, k_d;
    logic [KW-1:0]    nt_q, nt_d;

    // Reciprocal table floor(2^FRAC/k); entry 0 and entries past TERMS-1 are never selected.
    logic [WIDTH-1:0] recip_tab [2**KW];
    for (genvar g = 0; g < 2**KW; g++) begin : g_recip
        if (g == 0) begin : g_zero
            assign recip_tab[g] = '0;
        end else begin : g_val
            assign recip_tab[g] = WIDTH'((2**FRAC) / g);
        end
    end

    logic [KW-1:0]      nt_clamp;
    logic [WIDTH-1:0]   mul_b;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_sh;
    logic [WIDTH-1:0]   t_mul;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   r_sum;

    always_comb begin
        if (n_terms_i == '0) begin
            nt_clamp = KW'(1);
        end else if (n_terms_i > KW'(TERMS)) begin
            nt_clamp = KW'(TERMS);
        end else begin
            nt_clamp = n_terms_i;
        end
    end

    // Single multiplier: x during MUL_X, 1/k during MUL_R.
    assign mul_b   = (state_q == S_MUL_R) ? recip_tab[k_q] : xr_q;
    assign prod    = {{WIDTH{1'b0}}, t_q} * {{WIDTH{1'b0}}, mul_b};
    assign prod_sh = prod >> FRAC;
    assign t_mul   = (|prod_sh[2*WIDTH-1:WIDTH]) ? '1 : prod_sh[WIDTH-1:0];
    assign sum     = {1'b0, r_q} + {1'b0, t_q};
    assign r_sum   = sum[WIDTH] ? '1 : sum[WIDTH-1:0];

    always_comb begin
        state_d  = state_q;
        xr_d     = xr_q;
        t_d      = t_q;
        r_d      = r_q;
        k_d      = k_q;
        nt_d     = nt_q;
        result_d = result_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    xr_d    = x_i;
                    nt_d    = nt_clamp;
                    t_d     = ONE_FX;
                    r_d     = ONE_FX;
                    k_d     = KW'(1);
                    state_d = S_LOAD;
                end
            end
            S_LOAD:  state_d = (nt_q == KW'(1)) ? S_DONE : S_MUL_X;
            S_MUL_X: begin
                t_d     = t_mul;
                state_d = S_MUL_R;
            end
            S_MUL_R: begin
                t_d     = t_mul;
                state_d = S_ACC;
            end
            S_ACC: begin
                r_d     = r_sum;
                k_d     = k_q + KW'(1);
                state_d = ((k_q + KW'(1)) < nt_q) ? S_MUL_X : S_DONE;
            end
            S_DONE: begin
                if (out_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Capture the final sum, including the last ACC update, as DONE is entered.
        if (state_d == S_DONE && state_q != S_DONE) begin
            result_d = r_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q  <= S_IDLE;
            xr_q     <= '0;
            t_q      <= '0;
            r_q      <= '0;
            k_q      <= '0;
            nt_q     <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            xr_q     <= xr_d;
            t_q      <= t_d;
            r_q      <= r_d;
            k_q      <= k_d;
            nt_q     <= nt_d;
            result_q <= result_d;
        end
    end

    assign in_ready_o  = (state_q == S_IDLE);
    assign busy_o      = (state_q != S_IDLE);
    assign out_valid_o = (state_q == S_DONE);
    assign result_o    = result_q;

endmodule

// File: tb/tb_exp_series_engine.sv
// Directed bench for exp_series_engine: vector table plus throughput, back-pressure and reset sequences.
module tb_exp_series_engine;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] x;
    logic [3:0]  n_terms;
    logic        in_ready;
    logic        busy;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;

    int checks;
    int failures;

    exp_series_engine #(.WIDTH(16), .FRAC(14), .TERMS(8)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .x_i         (x),
        .n_terms_i   (n_terms),
        .in_ready_o  (in_ready),
        .busy_o      (busy),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .result_o    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] xv;
        logic [3:0]  nv;
        logic [15:0] res;
        int          lat;
    } vec_t;

    vec_t vt [10];

    task automatic check(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            if (in_ready) break;
            @(negedge clk);
        end
        check("idle_wait", in_ready, 1);
    endtask

    // Issue one request at a negedge and measure the cycle in which out_valid appears.
    task automatic run_vec(input logic [15:0] xv, input logic [3:0] nv,
                           input logic [15:0] er, input int el, input string nm);
        int cyc;
        bit got;
        wait_idle();
        x       = xv;
        n_terms = nv;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        got   = 1'b0;
        while (cyc < 100 && !got) begin
            if (out_valid) begin
                got = 1'b1;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        check({nm, "_lat"}, got ? cyc : -1, el);
        check({nm, "_res"}, result, er);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b0;
        start     = 1'b0;
        x         = '0;
        n_terms   = '0;
        out_ready = 1'b1;

        vt[0] = '{16'd8192,  4'd3,  16'd26624, 8};
        vt[1] = '{16'd8192,  4'd2,  16'd24576, 5};
        vt[2] = '{16'd8192,  4'd0,  16'd16384, 2};
        vt[3] = '{16'd8192,  4'd1,  16'd16384, 2};
        vt[4] = '{16'd8192,  4'd15, 16'd27011, 23};
        vt[5] = '{16'd65535, 4'd8,  16'd65535, 23};
        vt[6] = '{16'd16384, 4'd4,  16'd43690, 11};
        vt[7] = '{16'd0,     4'd5,  16'd16384, 14};
        vt[8] = '{16'd32768, 4'd3,  16'd65535, 8};
        vt[9] = '{16'd24576, 4'd2,  16'd40960, 5};

        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);

        for (int i = 0; i < 10; i++) begin
            run_vec(vt[i].xv, vt[i].nv, vt[i].res, vt[i].lat, $sformatf("vec%0d", i));
        end

        // Held start with out_ready high: second accept lands one cycle after DONE.
        wait_idle();
        x       = 16'd8192;
        n_terms = 4'd2;
        start   = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 5) begin
                check("tp_valid5", out_valid, 1);
                check("tp_inrdy5", in_ready, 0);
            end
            if (c == 6) begin
                check("tp_inrdy6", in_ready, 1);
                check("tp_valid6", out_valid, 0);
            end
            if (c == 7) begin
                check("tp_busy7", busy, 1);
                start = 1'b0;
            end
            if (c == 11) begin
                check("tp_valid11", out_valid, 1);
                check("tp_res11", result, 24576);
            end
        end

        // Back-pressure: DONE holds and ignores new starts.
        out_ready = 1'b0;
        run_vec(16'd8192, 4'd3, 16'd26624, 8, "bp");
        for (int i = 0; i < 5; i++) begin
            start   = 1'b1;
            x       = 16'($urandom_range(1, 65535));
            n_terms = 4'd1;
            @(negedge clk);
            check("bp_result", result, 26624);
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
            check("bp_busy", busy, 1);
        end
        start     = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_xfer_valid", out_valid, 0);
        check("bp_xfer_inrdy", in_ready, 1);
        @(negedge clk);
        check("bp_no_accept", busy, 0);

        // Reset during MUL_R of an 8-term run.
        wait_idle();
        x       = 16'd8192;
        n_terms = 4'd8;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("mid_rst_inrdy", in_ready, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_result", result, 0);
        run_vec(16'd0, 4'd8, 16'd16384, 23, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
